// File: rtl/run_control_monitor_pkg.sv
// Shared definitions for the run-control/halt monitor.
// State encodings and drain-counter width helper.
package run_control_monitor_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_END   = 2'd3
    } state_t;

    function automatic int drain_w(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/run_control_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module run_control_monitor_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/run_control_monitor.sv
// Run-control/halt monitor: counts cycles and retired ops,
// drains after the halt opcode, optional watchdog timeout.
module run_control_monitor
    import run_control_monitor_pkg::*;
#(
    parameter int              OP_W    = 6,
    parameter logic [OP_W-1:0] HALT_OP = '1,
    parameter int              CNT_W   = 32,
    parameter int              DRAIN   = 10,
    parameter int              TIMEOUT = 0
) (
    input  logic             sysclk,
    input  logic             cpu_resetn,
    input  logic             run_en,
    input  logic             clr,
    input  logic             op_valid,
    input  logic [OP_W-1:0]  op_w,
    output logic [ST_W-1:0]  state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] halt_cycle,
    output logic             done,
    output logic             timeout
);

    localparam int DW = drain_w(DRAIN);

    state_t        st;
    logic [DW-1:0] drain_cnt;
    logic          in_run;
    logic          cyc_en;
    logic          ins_en;
    logic          is_halt;
    logic          wd_hit;

    assign in_run  = run_en && (st == ST_RUN);
    assign cyc_en  = run_en && ((st == ST_RUN) || (st == ST_DRAIN));
    assign ins_en  = in_run && op_valid;
    assign is_halt = ins_en && (op_w == HALT_OP);
    // A zero limit disables the watchdog entirely
    assign wd_hit  = (TIMEOUT > 0) && in_run
                   && (cycle_cnt == CNT_W'(TIMEOUT - 1));
    assign state   = st;

    run_control_monitor_sat_counter #(.W(CNT_W)) u_cyc (
        .clk   (sysclk),
        .rst_n (cpu_resetn),
        .en    (cyc_en),
        .clr   (clr),
        .q     (cycle_cnt)
    );

    run_control_monitor_sat_counter #(.W(CNT_W)) u_ins (
        .clk   (sysclk),
        .rst_n (cpu_resetn),
        .en    (ins_en),
        .clr   (clr),
        .q     (instr_cnt)
    );

    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            st         <= ST_IDLE;
            drain_cnt  <= '0;
            halt_cycle <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else if (clr) begin
            st         <= ST_IDLE;
            drain_cnt  <= '0;
            halt_cycle <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            unique case (st)
                ST_IDLE: begin
                    if (run_en) st <= ST_RUN;
                end
                ST_RUN: begin
                    if (is_halt) begin
                        st         <= ST_DRAIN;
                        halt_cycle <= cycle_cnt;
                        drain_cnt  <= DW'(DRAIN - 1);
                    end else if (wd_hit) begin
                        st      <= ST_END;
                        timeout <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (run_en) begin
                        if (drain_cnt == '0) begin
                            st   <= ST_END;
                            done <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                end
                ST_END: begin
                    st <= ST_END;
                end
                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_control_monitor.sv
// Directed bench for run_control_monitor: three instances
// (default, TIMEOUT=50, CNT_W=4) share one stimulus stream.
module tb_run_control_monitor;

    logic       sysclk = 1'b0;
    logic       cpu_resetn = 1'b0;
    logic       run_en = 1'b0;
    logic       clr = 1'b0;
    logic       op_valid = 1'b0;
    logic [5:0] op_w = 6'h00;

    logic [1:0]  a_state, b_state, c_state;
    logic [31:0] a_cyc, a_ins, a_halt;
    logic [31:0] b_cyc, b_ins, b_halt;
    logic [3:0]  c_cyc, c_ins, c_halt;
    logic        a_done, a_to, b_done, b_to, c_done, c_to;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sysclk = ~sysclk;

    run_control_monitor dut_a (
        .sysclk(sysclk), .cpu_resetn(cpu_resetn), .run_en(run_en),
        .clr(clr), .op_valid(op_valid), .op_w(op_w),
        .state(a_state), .cycle_cnt(a_cyc), .instr_cnt(a_ins),
        .halt_cycle(a_halt), .done(a_done), .timeout(a_to)
    );

    run_control_monitor #(.TIMEOUT(50)) dut_b (
        .sysclk(sysclk), .cpu_resetn(cpu_resetn), .run_en(run_en),
        .clr(clr), .op_valid(op_valid), .op_w(op_w),
        .state(b_state), .cycle_cnt(b_cyc), .instr_cnt(b_ins),
        .halt_cycle(b_halt), .done(b_done), .timeout(b_to)
    );

    run_control_monitor #(.CNT_W(4)) dut_c (
        .sysclk(sysclk), .cpu_resetn(cpu_resetn), .run_en(run_en),
        .clr(clr), .op_valid(op_valid), .op_w(op_w),
        .state(c_state), .cycle_cnt(c_cyc), .instr_cnt(c_ins),
        .halt_cycle(c_halt), .done(c_done), .timeout(c_to)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    initial begin
        // Reset
        step(2);
        chk("rst_state", 32'(a_state), 32'd0);
        chk("rst_cyc",   a_cyc,  32'd0);
        chk("rst_ins",   a_ins,  32'd0);
        chk("rst_halt",  a_halt, 32'd0);
        chk("rst_done",  32'(a_done), 32'd0);
        chk("rst_to",    32'(a_to),   32'd0);
        cpu_resetn = 1'b1;
        step(1);
        chk("idle_hold", 32'(a_state), 32'd0);

        // 1: five NOPs then HALT at cycle 5
        run_en = 1'b1;
        step(1);
        chk("s1_run",     32'(a_state), 32'd1);
        chk("s1_cyc0",    a_cyc, 32'd0);
        for (int i = 0; i < 6; i++) begin
            op_valid = 1'b1;
            op_w = (i == 5) ? 6'h3F : 6'h00;
            step(1);
        end
        op_valid = 1'b0;
        op_w = 6'h00;
        chk("s1_drain",   32'(a_state), 32'd2);
        chk("s1_halt",    a_halt, 32'd5);
        chk("s1_ins",     a_ins,  32'd6);
        chk("s1_cyc6",    a_cyc,  32'd6);
        step(9);
        chk("s1_nodone",  32'(a_done), 32'd0);
        chk("s1_cyc15",   a_cyc, 32'd15);
        step(1);
        chk("s1_done",    32'(a_done), 32'd1);
        chk("s1_end",     32'(a_state), 32'd3);
        chk("s1_cyc16",   a_cyc, 32'd16);
        chk("s1_to",      32'(a_to), 32'd0);
        op_valid = 1'b1;
        step(3);
        op_valid = 1'b0;
        chk("s1_frz_cyc", a_cyc, 32'd16);
        chk("s1_frz_ins", a_ins, 32'd6);

        // 2: watchdog expiry on dut_b
        clr = 1'b1;
        step(1);
        chk("clr_state",  32'(a_state), 32'd0);
        chk("clr_cyc",    a_cyc, 32'd0);
        chk("clr_done",   32'(a_done), 32'd0);
        clr = 1'b0;
        step(1);
        step(49);
        chk("s2_b_run",   32'(b_state), 32'd1);
        chk("s2_b_cyc49", b_cyc, 32'd49);
        step(1);
        chk("s2_b_end",   32'(b_state), 32'd3);
        chk("s2_b_to",    32'(b_to), 32'd1);
        chk("s2_b_done",  32'(b_done), 32'd0);
        chk("s2_b_cyc",   b_cyc, 32'd50);
        chk("s2_a_nowd",  32'(a_state), 32'd1);
        chk("s2_a_cyc",   a_cyc, 32'd50);
        chk("s2_c_sat",   32'(c_cyc), 32'd15);
        step(2);
        chk("s2_b_frz",   b_cyc, 32'd50);

        // 3: HALT on the watchdog's last cycle
        clr = 1'b1;
        step(1);
        chk("s3_b_clr_to", 32'(b_to), 32'd0);
        clr = 1'b0;
        step(1);
        step(49);
        op_valid = 1'b1;
        op_w = 6'h3F;
        step(1);
        op_valid = 1'b0;
        op_w = 6'h00;
        chk("s3_b_drain", 32'(b_state), 32'd2);
        chk("s3_b_to0",   32'(b_to), 32'd0);
        chk("s3_b_halt",  b_halt, 32'd49);
        step(10);
        chk("s3_b_done",  32'(b_done), 32'd1);
        chk("s3_b_to1",   32'(b_to), 32'd0);
        chk("s3_b_cyc",   b_cyc, 32'd60);

        // 4: run_en dropped 3 cycles during DRAIN
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(1);
        for (int i = 0; i < 6; i++) begin
            op_valid = 1'b1;
            op_w = (i == 5) ? 6'h3F : 6'h00;
            step(1);
        end
        op_valid = 1'b0;
        op_w = 6'h00;
        step(4);
        run_en = 1'b0;
        step(3);
        chk("s4_pause_cyc", a_cyc, 32'd10);
        chk("s4_pause_st",  32'(a_state), 32'd2);
        run_en = 1'b1;
        step(5);
        chk("s4_nodone",  32'(a_done), 32'd0);
        step(1);
        chk("s4_done",    32'(a_done), 32'd1);
        chk("s4_cyc16",   a_cyc, 32'd16);
        chk("s4_halt",    a_halt, 32'd5);

        // 5: CNT_W=4 saturation with 20 valid NOPs
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(1);
        op_valid = 1'b1;
        step(15);
        chk("s5_c_ins15", 32'(c_ins), 32'd15);
        step(5);
        chk("s5_c_ins",   32'(c_ins), 32'd15);
        chk("s5_c_cyc",   32'(c_cyc), 32'd15);
        chk("s5_a_ins",   a_ins, 32'd20);

        // 6a: async reset mid-DRAIN
        op_w = 6'h3F;
        step(1);
        op_valid = 1'b0;
        op_w = 6'h00;
        step(3);
        chk("s6_pre_st",  32'(a_state), 32'd2);
        cpu_resetn = 1'b0;
        #1;
        chk("s6_ar_st",   32'(a_state), 32'd0);
        chk("s6_ar_cyc",  a_cyc,  32'd0);
        chk("s6_ar_ins",  a_ins,  32'd0);
        chk("s6_ar_halt", a_halt, 32'd0);
        chk("s6_ar_done", 32'(a_done), 32'd0);
        step(1);
        cpu_resetn = 1'b1;
        step(1);
        step(3);
        chk("s6_run_cyc", a_cyc, 32'd3);

        // 6b: clr beats HALT in the same cycle
        op_valid = 1'b1;
        op_w = 6'h3F;
        clr = 1'b1;
        step(1);
        op_valid = 1'b0;
        op_w = 6'h00;
        clr = 1'b0;
        chk("s6_clr_st",   32'(a_state), 32'd0);
        chk("s6_clr_cyc",  a_cyc,  32'd0);
        chk("s6_clr_ins",  a_ins,  32'd0);
        chk("s6_clr_halt", a_halt, 32'd0);
        chk("s6_clr_done", 32'(a_done), 32'd0);
        chk("s6_clr_to",   32'(a_to),   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
